// File: rtl/rmw_unit_pkg.sv
// Shared CPU definitions: ALU mode encodings, RMW opcodes and sequencer states.
package rmw_unit_pkg;

  localparam int ALU_MODE_W = 5;

  localparam logic [ALU_MODE_W-1:0] ALU_ADD = 5'd0;
  localparam logic [ALU_MODE_W-1:0] ALU_SUB = 5'd1;
  localparam logic [ALU_MODE_W-1:0] ALU_SR  = 5'd2;
  localparam logic [ALU_MODE_W-1:0] ALU_AND = 5'd3;
  localparam logic [ALU_MODE_W-1:0] ALU_OR  = 5'd4;
  localparam logic [ALU_MODE_W-1:0] ALU_EOR = 5'd5;

  typedef enum logic [2:0] {
    OP_ASL = 3'd0,
    OP_LSR = 3'd1,
    OP_ROL = 3'd2,
    OP_ROR = 3'd3,
    OP_INC = 3'd4,
    OP_DEC = 3'd5
  } rmw_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DUMMY = 2'd2,
    ST_WRITE = 2'd3
  } rmw_state_t;

  // Shifts and rotates update carry; INC/DEC leave it alone.
  function automatic logic op_writes_carry(input rmw_op_t op);
    return (op == OP_ASL) || (op == OP_LSR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/rmw_unit_alu.sv
// 8-bit CPU ALU, purely combinational; zero flag reflects the full 9-bit result.
module alu
  import rmw_unit_pkg::*;
(
  input  logic [7:0]            a,
  input  logic [7:0]            b,
  input  logic                  carry_in,
  input  logic [ALU_MODE_W-1:0] mode,
  output logic [7:0]            out,
  output logic                  carry_out,
  output logic                  zero
);

  logic [8:0] r;

  always_comb begin
    r = '0;
    case (mode)
      ALU_ADD: r = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
      // 6502-style subtract: carry_in=1 means no borrow.
      ALU_SUB: r = {1'b0, a} + {1'b0, ~b} + {8'd0, carry_in};
      ALU_SR:  r = {a[0], carry_in, a[7:1]};
      ALU_AND: r = {1'b0, a & b};
      ALU_OR:  r = {1'b0, a | b};
      ALU_EOR: r = {1'b0, a ^ b};
      default: r = '0;
    endcase
  end

  assign out       = r[7:0];
  assign carry_out = r[8];
  assign zero      = (r == 9'd0);

endmodule

// File: rtl/rmw_unit.sv
// 6502 read-modify-write sequencer: READ, dummy WRITE of original, WRITE of result.
// Start to done is 3 cycles plus one per mem_ready-low READ cycle; writes never stall.
module rmw_unit
  import rmw_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic              c_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              n_out,
  output logic              z_out,
  output logic              c_out,
  output logic              nz_we,
  output logic              c_we
);

  rmw_state_t state;
  rmw_op_t    op_q;
  logic       c_q;
  logic [7:0] data_q;

  logic [7:0]            alu_a;
  logic [7:0]            alu_b;
  logic                  alu_cin;
  logic [ALU_MODE_W-1:0] alu_mode;
  logic [7:0]            alu_out;
  logic                  alu_carry;
  logic                  alu_zero_unused;

  always_comb begin
    alu_a    = data_q;
    alu_b    = 8'd0;
    alu_cin  = 1'b0;
    alu_mode = ALU_ADD;
    case (op_q)
      OP_ASL: alu_b = data_q;
      OP_ROL: begin
        alu_b   = data_q;
        alu_cin = c_q;
      end
      OP_LSR: alu_mode = ALU_SR;
      OP_ROR: begin
        alu_mode = ALU_SR;
        alu_cin  = c_q;
      end
      OP_INC: alu_cin = 1'b1;
      OP_DEC: alu_mode = ALU_SUB;
      default: ;
    endcase
  end

  alu u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .carry_in  (alu_cin),
    .mode      (alu_mode),
    .out       (alu_out),
    .carry_out (alu_carry),
    .zero      (alu_zero_unused)
  );

  // mem_addr doubles as the latched operand address; mem_wdata holds the result in WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_ASL;
      c_q       <= 1'b0;
      data_q    <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= 8'd0;
      n_out     <= 1'b0;
      z_out     <= 1'b0;
      c_out     <= 1'b0;
      nz_we     <= 1'b0;
      c_we      <= 1'b0;
    end else begin
      done  <= 1'b0;
      nz_we <= 1'b0;
      c_we  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && (op <= 3'd5)) begin
            op_q     <= rmw_op_t'(op);
            c_q      <= c_in;
            mem_addr <= addr;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          if (mem_ready) begin
            data_q    <= mem_rdata;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b1;
            mem_wdata <= mem_rdata;
            state     <= ST_DUMMY;
          end
        end
        ST_DUMMY: begin
          mem_wdata <= alu_out;
          n_out     <= alu_out[7];
          z_out     <= (alu_out == 8'd0);
          if (op_writes_carry(op_q)) begin
            c_out <= alu_carry;
          end
          done  <= 1'b1;
          nz_we <= 1'b1;
          c_we  <= op_writes_carry(op_q);
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          busy      <= 1'b0;
          mem_wr    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= 8'd0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmw_unit.sv
// Bench for rmw_unit: directed vector table, stall/start/reset corner cases, random ops vs model.
module tb_rmw_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] addr;
  logic        c_in;
  logic        busy, done;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        n_out, z_out, c_out, nz_we, c_we;

  int n_checks = 0;
  int n_fail   = 0;

  rmw_unit #(.ADDR_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .n_out     (n_out),
    .z_out     (z_out),
    .c_out     (c_out),
    .nz_we     (nz_we),
    .c_we      (c_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  rdata;
    logic        cin;
    int          stalls;
    logic [7:0]  res;
    logic        c;
    logic        n;
    logic        z;
    logic        cwe;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bus_now();
    return {2'b00, busy, done, mem_rd, mem_wr, nz_we, c_we, mem_addr, mem_wdata};
  endfunction

  function automatic logic [31:0] bus_exp(input logic b, input logic d, input logic r,
                                          input logic w, input logic nz, input logic cw,
                                          input logic [15:0] a, input logic [7:0] wd);
    return {2'b00, b, d, r, w, nz, cw, a, wd};
  endfunction

  // Reference behaviour straight from the instruction definitions.
  task automatic model(input logic [2:0] o, input logic [7:0] d, input logic ci,
                       output logic [7:0] res, output logic c, output logic n,
                       output logic z, output logic cwe);
    int t;
    int di;
    di  = int'(d);
    t   = 0;
    c   = 1'b0;
    cwe = 1'b1;
    case (o)
      3'd0: begin t = di * 2;             c = (di >= 128); end
      3'd1: begin t = di / 2;             c = (di % 2 == 1); end
      3'd2: begin t = di * 2 + int'(ci);  c = (di >= 128); end
      3'd3: begin t = di / 2 + (ci ? 128 : 0); c = (di % 2 == 1); end
      3'd4: begin t = (di + 1) % 256;     cwe = 1'b0; end
      default: begin t = (di + 255) % 256; cwe = 1'b0; end
    endcase
    res = 8'(t % 256);
    n   = (res >= 8'd128);
    z   = (res == 8'd0);
  endtask

  // One full transaction, checked every cycle from edge 0 (accept) to the idle cycle after done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [7:0] rd, input logic ci, input int stalls,
                        input logic hold_start, input logic rst_dummy,
                        input logic [7:0] res, input logic c, input logic n,
                        input logic z, input logic cwe);
    @(negedge clk);
    op        = o;
    addr      = a;
    c_in      = ci;
    start     = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= stalls + 4; k++) begin
      @(negedge clk);
      if (k <= stalls + 1) begin
        check({tag, "/read"}, bus_now(), bus_exp(1, 0, 1, 0, 0, 0, a, 8'h00));
      end else if (k == stalls + 2) begin
        check({tag, "/dummy"}, bus_now(), bus_exp(1, 0, 0, 1, 0, 0, a, rd));
      end else if (k == stalls + 3) begin
        if (rst_dummy) begin
          check({tag, "/after_reset"}, bus_now(), 32'd0);
          check({tag, "/flags_reset"}, {29'd0, n_out, z_out, c_out}, 32'd0);
        end else begin
          check({tag, "/write"}, bus_now(), bus_exp(1, 1, 0, 1, 1, cwe, a, res));
          if (cwe) check({tag, "/nzc"}, {29'd0, n_out, z_out, c_out}, {29'd0, n, z, c});
          else     check({tag, "/nz"}, {30'd0, n_out, z_out}, {30'd0, n, z});
        end
      end else begin
        check({tag, "/idle"}, bus_now(), 32'd0);
        if (!rst_dummy) check({tag, "/nz_hold"}, {30'd0, n_out, z_out}, {30'd0, n, z});
      end
      if (!hold_start || k == stalls + 4) start = 1'b0;
      if (hold_start) begin
        op   = 3'($urandom_range(0, 5));
        addr = 16'($urandom);
        c_in = ~c_in;
      end
      mem_ready = (k >= stalls + 1);
      mem_rdata = (k == stalls + 1) ? rd : 8'($urandom);
      if (rst_dummy && k == stalls + 2) reset = 1'b1;
      if (rst_dummy && k == stalls + 3) reset = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] r;
    logic       mc, mn, mz, mcwe;
    logic [2:0] ro;
    logic [7:0] rdv;
    logic       rci;

    reset     = 1'b1;
    start     = 1'b0;
    op        = 3'd0;
    addr      = 16'h0;
    c_in      = 1'b0;
    mem_rdata = 8'h00;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_bus", bus_now(), 32'd0);
    check("reset_flags", {29'd0, n_out, z_out, c_out}, 32'd0);
    reset = 1'b0;

    //          op     addr      rdata  cin stalls res    c     n     z     cwe
    vecs[0] = '{3'd0, 16'h0200, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{3'd3, 16'h0010, 8'h01, 1'b1, 0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{3'd4, 16'hBEEF, 8'hFF, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{3'd5, 16'h00FF, 8'h00, 1'b1, 0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{3'd1, 16'h1234, 8'h03, 1'b0, 2, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{3'd2, 16'hFFFF, 8'h81, 1'b1, 1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].rdata, vecs[i].cin,
             vecs[i].stalls, 1'b0, 1'b0, vecs[i].res, vecs[i].c, vecs[i].n, vecs[i].z,
             vecs[i].cwe);
    end

    // Invalid op 6/7 in IDLE must not start anything.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd6;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("invalid_op_idle", bus_now(), 32'd0);
      op = (k % 2 == 0) ? 3'd7 : 3'd6;
    end
    start = 1'b0;

    // start held through the whole operation, including the done cycle.
    run_op("hold_start", 3'd0, 16'h4000, 8'h41, 1'b0, 1, 1'b1, 1'b0,
           8'h82, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset in DUMMY: no WRITE, no done.
    run_op("reset_dummy", 3'd4, 16'h0300, 8'h7F, 1'b0, 0, 1'b0, 1'b1,
           8'h80, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro  = 3'($urandom_range(0, 5));
      rdv = 8'($urandom);
      rci = 1'($urandom);
      model(ro, rdv, rci, r, mc, mn, mz, mcwe);
      run_op($sformatf("rand%0d", i), ro, 16'($urandom), rdv, rci,
             int'($urandom_range(0, 3)), 1'($urandom), 1'b0, r, mc, mn, mz, mcwe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rmw_unit.md
# rmw_unit

Read-modify-write sequencer for the 6502 memory-operand shift/rotate/increment instructions (ASL, LSR, ROL, ROR, INC, DEC). It drives the CPU-side ALU as its initiator and runs the NMOS bus pattern: read operand, dummy-write original, write result. Status-flag updates are returned to the CPU status register. It sits between the instruction decoder and the memory bus/ALU.

## Interface
- ADDR_W, 16, memory address width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0 and op is valid
- op  in  3  0=ASL 1=LSR 2=ROL 3=ROR 4=INC 5=DEC; 6,7 invalid
- addr  in  ADDR_W  operand address, latched on accept
- c_in  in  1  current carry flag, latched on accept
- busy  out  1  high from the cycle after accept through the WRITE cycle
- done  out  1  one-cycle pulse in the WRITE cycle
- mem_addr  out  ADDR_W  bus address
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid when mem_rd and mem_ready
- mem_ready  in  1  read-stall input (RDY); ignored on writes
- n_out, z_out, c_out  out  1 each  flag values, valid with done
- nz_we  out  1  pulses with done; always 1 at done
- c_we  out  1  pulses with done for shifts/rotates only; 0 for INC/DEC

## Operation
- FSM states: IDLE, READ, DUMMY, WRITE.
- IDLE: on start with op<=5, latch addr, op, c_in; go to READ. start with op 6/7 is ignored, and the FSM stays in IDLE.
- READ: mem_rd=1, mem_addr=addr_q. If mem_ready=1, capture mem_rdata into data_q and go to DUMMY. Otherwise hold READ with strobes unchanged.
- DUMMY: mem_wr=1, mem_wdata=data_q. The ALU evaluates this cycle; result_q and flags are registered at the end of the cycle. Go to WRITE.
- WRITE: mem_wr=1, mem_wdata=result_q, done=1, nz_we=1, c_we per op. Go to IDLE.
- ALU drive (a, b, carry_in, mode):
  - ASL: data, data, 0, ADD
  - ROL: data, data, c_q, ADD
  - LSR: data, 0, 0, SR
  - ROR: data, 0, c_q, SR
  - INC: data, 0, 1, ADD
  - DEC: data, 0, 0, SUB
- Result = ALU out[7:0].
- C = ALU carry_out. For SR, this is data[0].
- N = result[7].
- Z = (result[7:0]==0), computed locally. The ALU zero output is 9-bit based and is not used.
- Arithmetic wraps modulo 256: INC of 0xFF gives 0x00; DEC of 0x00 gives 0xFF.
- mem_addr holds addr_q in all non-IDLE states. mem_addr is 0 in IDLE.

## Timing
- Reset values: FSM in IDLE. busy, done, mem_rd, mem_wr, nz_we, c_we, n_out, z_out, c_out are 0. mem_addr=0, mem_wdata=0.
- Accept at edge 0 gives READ in cycle 1. With mem_ready=1: DUMMY in cycle 2, WRITE/done in cycle 3. Minimum latency is 3 cycles, start to done.
- Each cycle of mem_ready=0 in READ adds exactly one cycle.
- start during busy, including the done cycle, is ignored. The next accept is possible in the cycle after WRITE.
- Reset in any state returns to IDLE on the next edge. No further write occurs and no done is issued. A DUMMY write already on the bus in that cycle completes; no WRITE follows.
- Flag outputs hold their value after done until the next done. nz_we and c_we are single-cycle.

## Structure
- The shared CPU package holds:
  - the ALU mode encodings (ALU_ADD, ALU_SUB, ALU_SR, ...; 5 bits), shared with the ALU
  - an rmw_op_t enum for op
  - an rmw_state_t enum for the FSM
- Sub-module: one instance of the existing alu, driven combinationally from data_q, op_q and c_q.

## Test plan
- ASL, rdata=0x80, c_in=0 → DUMMY wdata=0x80, WRITE wdata=0x00; C=1, Z=1, N=0; c_we=1; done in cycle 3.
- ROR, rdata=0x01, c_in=1 → WRITE 0x80; C=1, N=1, Z=0.
- INC, rdata=0xFF → WRITE 0x00, Z=1, c_we=0. DEC, rdata=0x00 → WRITE 0xFF, N=1, c_we=0.
- LSR at 0x1234, mem_ready low for 2 cycles, rdata=0x03 → mem_addr=0x1234 throughout; done in cycle 5; WRITE 0x01, C=1.
- start asserted every cycle during an operation, plus start with op=6 in IDLE → exactly one sequence; the op=6 start produces no bus activity.
- reset asserted in DUMMY → next cycle all outputs at reset values; no WRITE and no done.
